// File: rtl/qsys_pio26_sequencer_pkg.sv
// Shared definitions for the PIO shield blocks: register map, bit positions,
// sequencer state encoding and the 26-bit pin lane packing helpers.
package qsys_pio26_pkg;

   localparam logic [4:0] REG_CTRL     = 5'd0;
   localparam logic [4:0] REG_STATUS   = 5'd1;
   localparam logic [4:0] REG_DIV      = 5'd2;
   localparam logic [4:0] REG_LEN      = 5'd3;
   localparam logic [4:0] REG_OE       = 5'd4;
   localparam logic [4:0] REG_CAPTURE  = 5'd5;
   localparam logic [4:0] REG_MASK     = 5'd6;
   localparam logic [4:0] REG_VALUE    = 5'd7;
   localparam logic [4:0] REG_IDX      = 5'd8;
   localparam logic [4:0] REG_DIRECT   = 5'd9;

   localparam int CTRL_START  = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_LOOP   = 2;
   localparam int CTRL_IRQ_EN = 3;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;
   localparam int STAT_MATCH = 2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_e;

   function automatic logic [31:0] pack26(input logic [25:0] d);
      return {4'b0000, d[25:22], d[21:14], d[13:6], 2'b00, d[5:0]};
   endfunction

   function automatic logic [25:0] unpack26(input logic [31:0] w);
      return {w[27:24], w[23:16], w[15:8], w[5:0]};
   endfunction

   // Each byte lane owns one slice of the 26-bit pin word.
   function automatic logic [25:0] be_merge26(input logic [25:0] old,
                                              input logic [31:0] w,
                                              input logic [3:0]  be);
      return {be[3] ? w[27:24] : old[25:22],
              be[2] ? w[23:16] : old[21:14],
              be[1] ? w[15:8]  : old[13:6],
              be[0] ? w[5:0]   : old[5:0]};
   endfunction

endpackage

// File: rtl/qsys_pio26_sequencer_if.sv
// Avalon-MM slave bus of the pattern sequencer.
interface qsys_pio26_sequencer_if;
   logic [4:0]  address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  byteenable;
   logic        write;
   logic        read;
   logic        waitrequest;

   modport master (output address, writedata, byteenable, write, read,
                   input  readdata, waitrequest);
   modport slave  (input  address, writedata, byteenable, write, read,
                   output readdata, waitrequest);
endinterface

// File: rtl/pio26_step_timer.sv
// Step-rate down-counter: load restarts the step, boundary flags the last
// clock of the current step while enabled.
module pio26_step_timer #(
   parameter int DIV_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             boundary_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign boundary_o = en_i && (cnt_q == '0);

   // Next count: load wins, otherwise decrement until zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - DIV_W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/qsys_pio26_sequencer.sv
// Avalon-MM pattern sequencer: plays programmed 26-bit words onto the shield
// pins at a programmable step rate, with input-match abort and interrupt.
module qsys_pio26_sequencer
   import qsys_pio26_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DIV_W = 16
) (
   input  logic                   csi_MCLK_clk,
   input  logic                   rsi_MRST_reset,
   qsys_pio26_sequencer_if.slave  avs_seq,
   output logic                   ins_INTRQ_irq,
   input  logic [25:0]            coe_input,
   output logic [25:0]            coe_output,
   output logic [25:0]            coe_en
);

   localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   seq_state_e       state_q, state_d;
   logic [LW-1:0]    idx_q, idx_d, len_q, len_d, idx_nx_s, pat_idx_s;
   logic [DIV_W-1:0] div_q, div_d;
   logic [25:0]      out_q, out_d, oe_q, oe_d, cap_q, cap_d;
   logic [25:0]      mask_q, mask_d, val_q, val_d;
   logic [25:0]      mem_q [DEPTH];
   logic [25:0]      mem_d [DEPTH];
   logic             loop_q, loop_d, irqen_q, irqen_d;
   logic             done_q, done_d, match_q, match_d, irq_q, irq_d;
   logic             wr_s, ctrl_wr_s, stat_wr_s, pat_hit_s, start_s, stop_s;
   logic             load_s, boundary_s;

   assign wr_s      = avs_seq.write;
   assign ctrl_wr_s = wr_s && (avs_seq.address == REG_CTRL) && avs_seq.byteenable[0];
   assign stat_wr_s = wr_s && (avs_seq.address == REG_STATUS) && avs_seq.byteenable[0];
   assign start_s   = ctrl_wr_s && avs_seq.writedata[CTRL_START];
   assign stop_s    = ctrl_wr_s && avs_seq.writedata[CTRL_STOP];
   assign pat_hit_s = avs_seq.address[4] && ({1'b0, avs_seq.address[3:0]} < 5'(DEPTH));
   assign pat_idx_s = LW'(avs_seq.address[3:0]);
   assign idx_nx_s  = idx_q + LW'(1'b1);

   pio26_step_timer #(.DIV_W(DIV_W)) u_timer (
      .clk_i      (csi_MCLK_clk),
      .rst_i      (rsi_MRST_reset),
      .load_i     (load_s),
      .load_val_i (div_q),
      .en_i       (state_q == ST_RUN),
      .boundary_o (boundary_s)
   );

   // Register writes, flag clears and the step sequencer; hardware flag sets come last so they beat W1C.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cap_d   = cap_q;
      load_s  = 1'b0;
      loop_d  = ctrl_wr_s ? avs_seq.writedata[CTRL_LOOP]   : loop_q;
      irqen_d = ctrl_wr_s ? avs_seq.writedata[CTRL_IRQ_EN] : irqen_q;
      done_d  = (stat_wr_s && avs_seq.writedata[STAT_DONE])  ? 1'b0 : done_q;
      match_d = (stat_wr_s && avs_seq.writedata[STAT_MATCH]) ? 1'b0 : match_q;
      div_d   = (wr_s && avs_seq.address == REG_DIV && avs_seq.byteenable != 4'b0000)
                ? avs_seq.writedata[DIV_W-1:0] : div_q;
      len_d   = (wr_s && avs_seq.address == REG_LEN && avs_seq.byteenable[0])
                ? avs_seq.writedata[LW-1:0] : len_q;
      oe_d    = (wr_s && avs_seq.address == REG_OE)
                ? be_merge26(oe_q, avs_seq.writedata, avs_seq.byteenable) : oe_q;
      mask_d  = (wr_s && avs_seq.address == REG_MASK)
                ? be_merge26(mask_q, avs_seq.writedata, avs_seq.byteenable) : mask_q;
      val_d   = (wr_s && avs_seq.address == REG_VALUE)
                ? be_merge26(val_q, avs_seq.writedata, avs_seq.byteenable) : val_q;
      out_d   = (wr_s && avs_seq.address == REG_DIRECT && state_q == ST_IDLE)
                ? be_merge26(out_q, avs_seq.writedata, avs_seq.byteenable) : out_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = (wr_s && pat_hit_s && pat_idx_s == LW'(i))
                    ? be_merge26(mem_q[i], avs_seq.writedata, avs_seq.byteenable) : mem_q[i];
      end

      case (state_q)
         ST_IDLE: begin
            if (start_s && !stop_s) begin
               state_d = ST_RUN;
               idx_d   = '0;
               out_d   = mem_q[0];
               load_s  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop_s) begin
               state_d = ST_IDLE;
            end else if (start_s) begin
               idx_d  = '0;
               out_d  = mem_q[0];
               load_s = 1'b1;
            end else if (boundary_s) begin
               cap_d = coe_input;
               if ((mask_q != 26'd0) && (((coe_input ^ val_q) & mask_q) == 26'd0)) begin
                  match_d = 1'b1;
                  state_d = ST_IDLE;
               end else if (idx_q < len_q) begin
                  idx_d  = idx_nx_s;
                  out_d  = mem_q[idx_nx_s];
                  load_s = 1'b1;
               end else if (loop_q) begin
                  idx_d  = '0;
                  out_d  = mem_q[0];
                  load_s = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      irq_d = irqen_q & (done_q | match_q);
   end

   // All architectural state; the pins come straight from these registers.
   always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
      if (rsi_MRST_reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         div_q   <= '0;
         out_q   <= 26'd0;
         oe_q    <= 26'd0;
         cap_q   <= 26'd0;
         mask_q  <= 26'd0;
         val_q   <= 26'd0;
         loop_q  <= 1'b0;
         irqen_q <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
         irq_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 26'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         div_q   <= div_d;
         out_q   <= out_d;
         oe_q    <= oe_d;
         cap_q   <= cap_d;
         mask_q  <= mask_d;
         val_q   <= val_d;
         loop_q  <= loop_d;
         irqen_q <= irqen_d;
         done_q  <= done_d;
         match_q <= match_d;
         irq_q   <= irq_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Zero-latency read mux; unused bits and reserved offsets read as zero.
   always_comb begin
      avs_seq.readdata = 32'd0;
      if (avs_seq.read) begin
         case (avs_seq.address)
            REG_CTRL:    avs_seq.readdata = {28'd0, irqen_q, loop_q, 2'b00};
            REG_STATUS:  avs_seq.readdata = {29'd0, match_q, done_q, state_q == ST_RUN};
            REG_DIV:     avs_seq.readdata = 32'(div_q);
            REG_LEN:     avs_seq.readdata = 32'(len_q);
            REG_OE:      avs_seq.readdata = pack26(oe_q);
            REG_CAPTURE: avs_seq.readdata = pack26(cap_q);
            REG_MASK:    avs_seq.readdata = pack26(mask_q);
            REG_VALUE:   avs_seq.readdata = pack26(val_q);
            REG_IDX:     avs_seq.readdata = 32'(idx_q);
            REG_DIRECT:  avs_seq.readdata = pack26(out_q);
            default:     avs_seq.readdata = pat_hit_s ? pack26(mem_q[pat_idx_s]) : 32'd0;
         endcase
      end else begin
         avs_seq.readdata = 32'd0;
      end
   end

   assign avs_seq.waitrequest = 1'b0;
   assign ins_INTRQ_irq       = irq_q;
   assign coe_output          = out_q;
   assign coe_en              = oe_q;

endmodule
